// File: rtl/lif_spike_encoder.sv
// lif_spike_encoder: rate-codes one pixel intensity into a WINDOW-cycle spike train
// that drives the LIF neuron's enable / input_spike pins.
// Handshake: pix_valid/pix_ready. Only one pixel is in flight at a time.
// Optional macro LIF_ENC_LFSR_EN selects stochastic coding with a 16-bit Galois
// LFSR (DATA_W must be <= 16). Without the macro, deterministic accumulator coding
// is built and no LFSR logic exists.
module lif_spike_encoder #(
  parameter int DATA_W = 8,
  parameter int WINDOW = 16,
  parameter int CNT_W  = $clog2(WINDOW + 1)
`ifdef LIF_ENC_LFSR_EN
  ,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  input  logic              hold,
  output logic              enable,
  output logic              input_spike,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  spike_count
);

  // Step counter only needs to reach WINDOW-1.
  localparam int STEP_W = $clog2(WINDOW);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE,
    ENCODE,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_W-1:0] intensity;
  logic [STEP_W-1:0] step;
  logic              accept;
  logic              advance;
  logic              last_step;
  logic              spike;

  assign pix_ready = (state == IDLE);
  assign accept    = pix_valid & pix_ready;
  assign advance   = (state == ENCODE) & ~hold;
  assign last_step = (step == LAST_STEP);

  // State register; reset returns to IDLE and abandons any window in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a window ends after the last non-held step, DONE lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ENCODE;
      ENCODE:  if (advance && last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef LIF_ENC_LFSR_EN

  logic [15:0] lfsr;
  logic [15:0] lfsr_next;

  // Stochastic spike decision and Galois shift (taps x^16+x^14+x^13+x^11+1).
  always_comb begin
    spike     = (lfsr[DATA_W-1:0] < intensity);
    lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
  end

  // LFSR advances on every non-held step and is reseeded only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      lfsr <= lfsr_next;
    end
  end

`else

  logic [DATA_W-1:0] acc;
  logic [DATA_W:0]   sum;

  // Accumulator coding: the carry out of acc+intensity is the spike.
  always_comb begin
    sum   = {1'b0, acc} + {1'b0, intensity};
    spike = sum[DATA_W];
  end

  // Accumulator restarts from zero for every pixel and is frozen while held.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (accept) begin
      acc <= '0;
    end else if (advance) begin
      acc <= sum[DATA_W-1:0];
    end
  end

`endif

  // Datapath and registered outputs: latch pixel, step the window, emit enable/spike/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      intensity   <= '0;
      step        <= '0;
      spike_count <= '0;
      enable      <= 1'b0;
      input_spike <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      enable      <= 1'b0;
      input_spike <= 1'b0;
      done        <= (state == DONE);
      if (accept) begin
        intensity   <= pix_data;
        step        <= '0;
        spike_count <= '0;
        busy        <= 1'b1;
      end
      if (advance) begin
        step        <= step + 1'b1;
        enable      <= 1'b1;
        input_spike <= spike;
        spike_count <= spike_count + {{(CNT_W-1){1'b0}}, spike};
        if (last_step) begin
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lif_spike_encoder.sv
// tb_lif_spike_encoder: randomized self-checking bench for lif_spike_encoder.
// Reference model counts spikes from the rate-coding arithmetic directly
// (floor((k+1)*I/2^W) - floor(k*I/2^W)) or, with LIF_ENC_LFSR_EN, from a
// free-running LFSR sequence that is reseeded only on reset.
module tb_lif_spike_encoder;

  localparam int DATA_W = 8;
  localparam int WINDOW = 16;
  localparam int CNT_W  = $clog2(WINDOW + 1);
  localparam logic [15:0] SEED = 16'hACE1;

  logic              clk = 1'b0;
  logic              rst;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_ready;
  logic              hold;
  logic              enable;
  logic              input_spike;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  spike_count;

  int          numCompared   = 0;
  int          numMismatched = 0;
  logic [15:0] lfsrModel     = SEED;

  lif_spike_encoder #(
    .DATA_W(DATA_W),
    .WINDOW(WINDOW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .hold       (hold),
    .enable     (enable),
    .input_spike(input_spike),
    .busy       (busy),
    .done       (done),
    .spike_count(spike_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    numCompared++;
    if (observed != expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference spike for step k of a pixel of the given intensity.
  task automatic nextModelSpike(input int intensity, input int k, output int s);
`ifdef LIF_ENC_LFSR_EN
    s = (int'(lfsrModel[DATA_W-1:0]) < intensity) ? 1 : 0;
    lfsrModel = lfsrModel[0] ? ((lfsrModel >> 1) ^ 16'hB400) : (lfsrModel >> 1);
`else
    s = ((k + 1) * intensity) / (1 << DATA_W) - (k * intensity) / (1 << DATA_W);
`endif
  endtask

  // One pixel transaction.
  // holdMode: 0 never hold, 1 random holds, 2 five-cycle burst after step 4.
  // resetAtStep >= 0 asserts rst once that many steps have been taken.
  task automatic applyStimulus(input int data, input int holdMode, input bit garbageValid,
                               input int resetAtStep);
    int waitCycles;
    int k;
    int s;
    int expCount;
    int loops;
    bit holdPrev;

    waitCycles = 0;
    while (!pix_ready && waitCycles < 50) begin
      tick;
      waitCycles++;
    end
    checkOutput("ready_before_accept", pix_ready, 1);

    pix_valid = 1'b1;
    pix_data  = DATA_W'(data);
    hold      = 1'b0;
    tick;
    checkOutput("busy_after_accept", busy, 1);
    checkOutput("ready_after_accept", pix_ready, 0);
    checkOutput("enable_before_first_step", enable, 0);
    checkOutput("count_cleared_on_accept", spike_count, 0);
    if (garbageValid) pix_data = DATA_W'(data ^ 8'hFF);
    else pix_valid = 1'b0;

    k = 0;
    expCount = 0;
    loops = 0;
    while (k < WINDOW) begin
      if (resetAtStep == k) begin
        rst = 1'b1;
        tick;
        checkOutput("rst_mid_done", done, 0);
        checkOutput("rst_mid_count", spike_count, 0);
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_enable", enable, 0);
        checkOutput("rst_mid_ready", pix_ready, 1);
        rst = 1'b0;
        pix_valid = 1'b0;
        lfsrModel = SEED;
        tick;
        checkOutput("after_rst_done", done, 0);
        checkOutput("after_rst_busy", busy, 0);
        checkOutput("after_rst_ready", pix_ready, 1);
        return;
      end
      case (holdMode)
        1:       hold = ($urandom_range(0, 3) == 0);
        2:       hold = (loops >= 5 && loops < 10);
        default: hold = 1'b0;
      endcase
      if (loops > 100) hold = 1'b0;
      holdPrev = hold;
      tick;
      loops++;
      if (!holdPrev) begin
        nextModelSpike(data, k, s);
        expCount += s;
        k++;
        checkOutput("enable_on_step", enable, 1);
        checkOutput("spike_on_step", input_spike, s);
      end else begin
        checkOutput("enable_on_hold", enable, 0);
        checkOutput("spike_on_hold", input_spike, 0);
      end
      checkOutput("count_running", spike_count, expCount);
      checkOutput("done_low_in_window", done, 0);
      if (k < WINDOW) begin
        checkOutput("busy_in_window", busy, 1);
        checkOutput("ready_in_window", pix_ready, 0);
      end
    end

    // DONE state cycle
    checkOutput("busy_in_done", busy, 0);
    checkOutput("ready_in_done", pix_ready, 0);
    checkOutput("done_not_early", done, 0);
    pix_valid = 1'b0;
    hold = 1'($urandom_range(0, 1));
    tick;
    checkOutput("done_pulse", done, 1);
    checkOutput("ready_after_done", pix_ready, 1);
    checkOutput("busy_after_done", busy, 0);
    checkOutput("enable_after_done", enable, 0);
    checkOutput("count_final", spike_count, expCount);
`ifndef LIF_ENC_LFSR_EN
    checkOutput("count_closed_form", spike_count, (WINDOW * data) / (1 << DATA_W));
`endif
    hold = 1'b0;
    tick;
    checkOutput("done_one_cycle", done, 0);
    checkOutput("count_held", spike_count, expCount);
    checkOutput("idle_not_busy", busy, 0);
  endtask

  // Main sequence: reset, directed boundary cases, then randomized pixels.
  initial begin
    rst       = 1'b1;
    pix_valid = 1'b1;
    pix_data  = 8'd77;
    hold      = 1'b0;
    tick;
    tick;
    checkOutput("reset_enable", enable, 0);
    checkOutput("reset_spike", input_spike, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_count", spike_count, 0);
    rst = 1'b0;
    pix_valid = 1'b0;
    lfsrModel = SEED;
    tick;
    checkOutput("release_ready", pix_ready, 1);
    checkOutput("release_busy", busy, 0);
    checkOutput("release_done", done, 0);

    $display("[TB] directed pixels");
    applyStimulus(128, 0, 1'b0, -1);
    applyStimulus(0, 0, 1'b1, -1);
    applyStimulus(255, 0, 1'b0, -1);
    applyStimulus(64, 2, 1'b0, -1);
    applyStimulus(200, 0, 1'b1, 7);
    applyStimulus(255, 1, 1'b0, -1);

    $display("[TB] random pixels");
    for (int i = 0; i < 24; i++) begin
      applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
